// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the mips_cpu_harvard fetch stage.
// Fetch states, reset/halt addresses and instruction width.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDR_DEF    = 32'h00000000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/mips_cpu_fetch.sv
// Fetch stage: PC, branch delay slot, halt-on-jump-to-zero.
// MIPS_FETCH_ALIGN_CHECK_EN enables misaligned-target faulting.
module mips_cpu_fetch
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        stall,
  input  logic        branch_req,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_address,
  output logic [31:0] link_address,
  output logic        active,
  output logic        fault
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  r_target;
  logic [31:0]  w_target_nxt;
  logic [31:0]  w_target_cap;
  logic         w_adv;
  logic         w_misaligned;

  assign w_adv = clk_enable & ~stall;

`ifdef MIPS_FETCH_ALIGN_CHECK_EN
  assign w_target_cap = branch_target;
  assign w_misaligned = |r_target[1:0];
`else
  assign w_target_cap = {branch_target[31:2], 2'b00};
  assign w_misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= RUN;
      r_pc     <= RESET_VECTOR;
      r_target <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_target <= w_target_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_target_nxt = r_target;
    if (w_adv) begin
      unique case (r_state)
        RUN: begin
          w_pc_nxt = r_pc + INSTR_BYTES;
          if (branch_req) begin
            w_target_nxt = w_target_cap;
            w_state_nxt  = DELAY;
          end
        end
        DELAY: begin
          // A misaligned target never reaches the PC.
          if (w_misaligned) begin
            w_state_nxt = FAULT;
          end else begin
            w_pc_nxt    = r_target;
            w_state_nxt = (r_target == HALT_ADDR)
                          ? HALTED : RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    instr_address = r_pc;
    link_address  = r_pc + 2 * INSTR_BYTES;
    active        = (r_state == RUN)
                  || (r_state == DELAY);
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    fault         = (r_state == FAULT);
`else
    fault         = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// Directed bench for mips_cpu_fetch.
// Follows MIPS_FETCH_ALIGN_CHECK_EN for the misaligned case.
module tb_mips_cpu_fetch;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        stall;
  logic        branch_req;
  logic [31:0] branch_target;
  logic [31:0] instr_address;
  logic [31:0] link_address;
  logic        active;
  logic        fault;

  int checks;
  int errors;

  mips_cpu_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .stall         (stall),
    .branch_req    (branch_req),
    .branch_target (branch_target),
    .instr_address (instr_address),
    .link_address  (link_address),
    .active        (active),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    clk_enable    = 1'b1;
    stall         = 1'b0;
    branch_req    = 1'b0;
    branch_target = '0;
    @(negedge clk);

    // 1: reset state and sequential fetch
    do_reset();
    chk("rst_pc", instr_address, 32'hBFC00000);
    chk("rst_act", {31'b0, active}, 32'd1);
    chk("rst_flt", {31'b0, fault}, 32'd0);
    chk("rst_link", link_address, 32'hBFC00008);
    tick();
    chk("seq1", instr_address, 32'hBFC00004);
    tick();
    tick();
    chk("seq3", instr_address, 32'hBFC0000C);

    // 2: taken branch with delay slot; branch in slot ignored
    do_reset();
    tick();
    branch_req    = 1'b1;
    branch_target = 32'hBFC00100;
    tick();
    chk("br_slot", instr_address, 32'hBFC00008);
    branch_target = 32'hBFC00300;
    tick();
    branch_req = 1'b0;
    chk("br_tgt", instr_address, 32'hBFC00100);
    tick();
    chk("br_next", instr_address, 32'hBFC00104);

    // 3: jr $0 halts after the delay slot
    do_reset();
    tick();
    tick();
    branch_req    = 1'b1;
    branch_target = 32'h0;
    tick();
    branch_req = 1'b0;
    chk("halt_slot", instr_address, 32'hBFC0000C);
    chk("halt_slot_act", {31'b0, active}, 32'd1);
    tick();
    chk("halt_pc", instr_address, 32'h0);
    chk("halt_act", {31'b0, active}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      branch_req    = i[0];
      branch_target = 32'hBFC00100;
      tick();
    end
    branch_req = 1'b0;
    chk("halt_hold", instr_address, 32'h0);
    chk("halt_hold_act", {31'b0, active}, 32'd0);
    chk("halt_link", link_address, 32'h8);

    // 4: stall and clk_enable freeze the PC
    do_reset();
    tick();
    stall = 1'b1;
    tick();
    tick();
    chk("stall", instr_address, 32'hBFC00004);
    stall      = 1'b0;
    clk_enable = 1'b0;
    tick();
    tick();
    chk("clken", instr_address, 32'hBFC00004);
    clk_enable = 1'b1;
    tick();
    chk("resume", instr_address, 32'hBFC00008);

    // 5: reset in DELAY, even with clk_enable low
    do_reset();
    tick();
    branch_req    = 1'b1;
    branch_target = 32'hBFC00200;
    tick();
    branch_req = 1'b0;
    chk("d_slot", instr_address, 32'hBFC00008);
    clk_enable = 1'b0;
    do_reset();
    clk_enable = 1'b1;
    chk("d_rst", instr_address, 32'hBFC00000);
    chk("d_rst_act", {31'b0, active}, 32'd1);
    tick();
    tick();
    chk("d_drop", instr_address, 32'hBFC00008);

    // wrap past zero by fall-through does not halt
    do_reset();
    branch_req    = 1'b1;
    branch_target = 32'hFFFFFFF8;
    tick();
    branch_req = 1'b0;
    tick();
    chk("w_tgt", instr_address, 32'hFFFFFFF8);
    tick();
    chk("w_link", link_address, 32'h4);
    tick();
    chk("w_zero", instr_address, 32'h0);
    chk("w_act", {31'b0, active}, 32'd1);
    tick();
    chk("w_next", instr_address, 32'h4);

    // 6: misaligned target
    do_reset();
    tick();
    branch_req    = 1'b1;
    branch_target = 32'hBFC00102;
    tick();
    branch_req = 1'b0;
    chk("m_slot", instr_address, 32'hBFC00008);
    tick();
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    chk("m_pc", instr_address, 32'hBFC00008);
    chk("m_flt", {31'b0, fault}, 32'd1);
    chk("m_act", {31'b0, active}, 32'd0);
    tick();
    chk("m_hold", instr_address, 32'hBFC00008);
`else
    chk("m_pc", instr_address, 32'hBFC00100);
    chk("m_flt", {31'b0, fault}, 32'd0);
    chk("m_act", {31'b0, active}, 32'd1);
    tick();
    chk("m_next", instr_address, 32'hBFC00104);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
